ram_stream_reader: RTL and testbench
====================================

Name: ram_stream_reader

Overview:
- Read-side initiator for the single-write/dual-read synchronous RAM.
- Given a base address and a word count, it issues sequential read addresses on read port 1 and absorbs the RAM's 1-cycle read latency in a small internal FIFO.
- It presents the words as a valid/ready stream with a last flag.
- Typical use: the card/deck fetch engine streaming stored words to game logic without that logic tracking RAM timing.

Parameters:
- DATA_WIDTH, 32, RAM word width.
- ADDRESS_WIDTH, 12, RAM address width; addresses wrap modulo 2^ADDRESS_WIDTH.
- FIFO_DEPTH, 2, output buffer entries; power of two, >= 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin transfer; sampled only when busy=0.
- base_addr  in  ADDRESS_WIDTH  first word address; captured with start.
- length  in  ADDRESS_WIDTH+1  word count, 0..2^ADDRESS_WIDTH; captured with start.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at transfer completion.
- ram_wEn  out  1  RAM write enable; constant 0 (a RAM write suppresses reads).
- ram_addr  out  ADDRESS_WIDTH  RAM read address (port addr).
- ram_rdata  in  DATA_WIDTH  RAM dataOut.
- m_valid  out  1  stream word available.
- m_ready  in  1  consumer accepts word.
- m_data  out  DATA_WIDTH  stream word.
- m_last  out  1  marks the final word of the transfer; qualified by m_valid.

Behaviour:
- Reset, asynchronous and active-low. Outputs go to: busy=0, done=0, ram_wEn=0, ram_addr=0, m_valid=0, m_data=0, m_last=0. FIFO, counters and in-flight flag clear. State=IDLE.
- Reset mid-transfer: all state is abandoned and no done pulse is produced.

States:
- IDLE
  - start=1 with length>0: capture base_addr and length, set issue_cnt=0, go to FETCH, busy=1.
  - start=1 with length=0: stay IDLE, pulse done on the next cycle, emit no words.
- FETCH
  - Issue condition: issue_cnt<length AND (fifo_count + inflight - pop) < FIFO_DEPTH, where pop = m_valid&m_ready.
  - On issue: ram_addr = (base + issue_cnt) mod 2^ADDRESS_WIDTH, inflight<=1, issue_cnt++.
  - When issue_cnt reaches length, go to DRAIN.
- DRAIN
  - No further issues; wait until the FIFO is empty and inflight=0 after the last pop.
  - On that final pop: done=1 for one cycle, busy<=0, return to IDLE.

Read timing:
- An address issued in cycle t is registered by the RAM at the end of t.
- ram_rdata is pushed into the FIFO at the end of t+1 (inflight flag). m_valid can rise in cycle t+2.
- The first m_valid occurs exactly 2 cycles after the start sampling edge.

Address and data path:
- ram_addr holds its last value when not issuing. The resulting re-reads are harmless and are not pushed.

Stream rules:
- m_data/m_valid/m_last come from the FIFO head. m_data is stable while m_valid=1 and m_ready=0.
- m_last=1 exactly on word index length-1.
- Push and pop in the same cycle are legal; count is unchanged.
- FIFO never overflows: guaranteed by the issue condition, no data loss under any m_ready pattern.

Throughput and control:
- Throughput is 1 word/cycle with m_ready held high, at FIFO_DEPTH=2.
- start while busy=1 is ignored.
- done and start in the same cycle: the new start is accepted only on the following cycle, since busy drops at the done edge.
- length=2^ADDRESS_WIDTH reads every address once, wrapping through 0.

Test Plan:
- Preload RAM[0x10..0x13]=A0,A1,A2,A3; start base=0x10, len=4, m_ready=1 -> m_valid high cycles 2..5; data A0..A3; m_last on A3; done pulse cycle 5; ram_wEn always 0.
- Same transfer, m_ready toggling 1,0,0,1,... -> words A0..A3 in order, no duplicates or drops, m_data stable while stalled, FIFO count never exceeds 2.
- base=0xFFE, len=4 -> addresses 0xFFE,0xFFF,0x000,0x001 and corresponding data.
- len=0 -> done pulse next cycle; m_valid never asserted; busy stays 0.
- Pulse start again mid-transfer with a different base -> ignored; the original stream completes unchanged.
- Assert reset_n=0 after 2 words of a len=8 transfer -> outputs immediately at reset values, no done. A new start len=1 afterwards returns the correct single word with m_last=1.

Source files
------------

// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//   Read-side initiator for the single-write/dual-read synchronous RAM.
//   A transfer is launched with start (base_addr, length captured when busy=0).
//   Sequential read addresses go out on RAM read port 1. The RAM's one-cycle
//   read latency is absorbed by a small FIFO. Words are then presented as a
//   valid/ready stream, and m_last marks the final word.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 launch a transfer (ignored while busy)
//   base_addr, length     first address and word count (0..2^ADDRESS_WIDTH)
//   busy, done            transfer in progress / one-cycle completion pulse
//   ram_wEn               RAM write enable, tied low
//   ram_addr, ram_rdata   RAM read address / read data (registered in the RAM)
//   m_valid, m_ready      output stream handshake
//   m_data, m_last        stream word and final-word flag
module ram_stream_reader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   length,
  output logic                     busy,
  output logic                     done,
  output logic                     ram_wEn,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0]    ram_rdata,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_last
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 2;
  localparam int LEN_W = ADDRESS_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] base_q;
  logic [ADDRESS_WIDTH-1:0] addr_hold_q;
  logic [LEN_W-1:0]         len_q;
  logic [LEN_W-1:0]         issue_cnt_q;
  logic                     zero_done_q;

  logic                     vld_p1;
  logic                     last_p1;

  logic [DATA_WIDTH-1:0]    fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]    fifo_last_q;
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]         count_q;

  logic                     pop;
  logic                     push;
  logic [CNT_W-1:0]         occupancy;
  logic                     issue;
  logic                     issue_last;
  logic [ADDRESS_WIDTH-1:0] issue_addr;
  logic                     final_pop;
  logic                     accept_start;

  assign ram_wEn = 1'b0;
  assign busy    = (state_q != IDLE);

  assign m_valid = (count_q != '0);
  assign m_data  = m_valid ? fifo_data[rd_ptr_q] : '0;
  assign m_last  = m_valid & fifo_last_q[rd_ptr_q];

  assign pop  = m_valid & m_ready;
  assign push = vld_p1;

  // Slots already committed: stored words plus the read still in flight,
  // minus the word leaving this cycle. Issuing only below DEPTH keeps the
  // FIFO from overflowing whatever m_ready does.
  assign occupancy  = count_q + CNT_W'(vld_p1) - CNT_W'(pop);
  assign issue      = (state_q == FETCH) && (issue_cnt_q < len_q) && (occupancy < DEPTH_C);
  assign issue_addr = base_q + issue_cnt_q[ADDRESS_WIDTH-1:0];
  assign issue_last = (issue_cnt_q == len_q - LEN_W'(1));

  // The RAM registers the address in the issuing cycle. When not issuing,
  // the last address is held so the bus stays quiet. Those re-reads are
  // never pushed.
  assign ram_addr = issue ? issue_addr : addr_hold_q;

  // The last word only leaves the FIFO after DRAIN has been entered.
  assign final_pop    = (state_q == DRAIN) && pop && m_last;
  assign done         = zero_done_q | final_pop;
  assign accept_start = (state_q == IDLE) && start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_start && (length != '0)) state_d = FETCH;
      FETCH:   if (issue && (issue_cnt_q + LEN_W'(1) == len_q)) state_d = DRAIN;
      DRAIN:   if (final_pop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- p0: transfer control and address issue ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      addr_hold_q <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      zero_done_q <= accept_start && (length == '0);
      if (accept_start) begin
        base_q      <= base_addr;
        len_q       <= length;
        issue_cnt_q <= '0;
      end else if (issue) begin
        issue_cnt_q <= issue_cnt_q + LEN_W'(1);
      end
      if (issue) addr_hold_q <= issue_addr;
    end
  end

  // ---- p1: RAM read in flight, data returns next cycle ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= issue;
      last_p1 <= issue & issue_last;
    end
  end

  // ---- p2: output FIFO, written with ram_rdata while a read is in flight ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fifo_last_q <= '0;
    end else begin
      if (push) begin
        fifo_last_q[wr_ptr_q] <= last_p1;
        wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_data[wr_ptr_q] <= ram_rdata;
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader
//   Directed bench for ram_stream_reader. It includes a behavioural
//   synchronous RAM on the read port. Expected words go into a queue when a
//   transfer is started. A negedge monitor pops the queue on every accepted
//   word and also watches ram_wEn and data stability under back-pressure.
module tb_ram_stream_reader;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int FD = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy, done, ram_wEn;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;

  logic [DW-1:0] mem [1<<AW];
  logic [DW:0]   exp_q [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_stream_reader #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .ram_wEn(ram_wEn),
    .ram_addr(ram_addr), .ram_rdata(ram_rdata), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  // synchronous RAM read port, one-cycle latency
  always @(posedge clk) ram_rdata <= mem[ram_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // stream monitor
  logic        stall_q = 1'b0;
  logic [DW:0] stall_v;
  logic [DW:0] w;
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_q <= 1'b0;
    end else begin
      check("ram_wEn", 64'(ram_wEn), 64'd0);
      if (stall_q && m_valid) check("stall_hold", 64'({m_last, m_data}), 64'(stall_v));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word_pending", 64'(exp_q.size()), 64'd1);
        end else begin
          w = exp_q.pop_front();
          check("word", 64'({m_last, m_data}), 64'(w));
        end
      end
      stall_q <= m_valid && !m_ready;
      stall_v <= {m_last, m_data};
    end
  end

  // Call mid-cycle. Start is sampled at the next posedge, and the task
  // returns #1 after it, which is cycle 0 of the transfer.
  task automatic start_xfer(input logic [AW-1:0] b, input logic [AW:0] l);
    logic [AW-1:0] a;
    start     = 1'b1;
    base_addr = b;
    length    = l;
    for (int i = 0; i < int'(l); i++) begin
      a = b + AW'(i);
      exp_q.push_back({(i == int'(l) - 1), mem[a]});
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // m_ready mode: 0 always high, 1 pattern 1,0,0 repeating, 2 random
  task automatic run_wait(input int mode, input int restart_at, input int limit,
                          output int cyc, output int first_v, output logic busy0);
    cyc     = -1;
    first_v = -1;
    busy0   = 1'b0;
    for (int k = 0; k < limit; k++) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (k % 3 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (k == restart_at) begin
        start = 1'b1; base_addr = 12'h300; length = 13'd3;
      end else if (k == restart_at + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
      if (k == 0) busy0 = busy;
      if (m_valid && first_v < 0) first_v = k;
      if (done) begin
        cyc = k;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (cyc < 0) check("done_timeout", 64'(cyc), 64'd0);
  endtask

  task automatic finish_xfer(input string tag);
    @(posedge clk);
    #1 m_ready = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check({tag, "_done_single"}, 64'(done), 64'd0);
    check({tag, "_busy_clear"}, 64'(busy), 64'd0);
    check({tag, "_valid_clear"}, 64'(m_valid), 64'd0);
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  int   cyc, fv;
  logic b0;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h5A00_0000 ^ (i * 32'h0001_0003);
    mem[16] = 32'hA0; mem[17] = 32'hA1; mem[18] = 32'hA2; mem[19] = 32'hA3;
    reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wen", 64'(ram_wEn), 64'd0);
    check("rst_addr", 64'(ram_addr), 64'd0);
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_data", 64'(m_data), 64'd0);
    check("rst_last", 64'(m_last), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // basic transfer, full throughput
    start_xfer(12'h010, 13'd4);
    run_wait(0, -1, 50, cyc, fv, b0);
    check("t1_first_valid", 64'(fv), 64'd2);
    check("t1_done_cycle", 64'(cyc), 64'd5);
    check("t1_busy", 64'(b0), 64'd1);
    finish_xfer("t1");

    // same transfer under back-pressure
    start_xfer(12'h010, 13'd4);
    run_wait(1, -1, 100, cyc, fv, b0);
    finish_xfer("t2");

    // address wrap
    start_xfer(12'hFFE, 13'd4);
    run_wait(0, -1, 50, cyc, fv, b0);
    check("t3_done_cycle", 64'(cyc), 64'd5);
    finish_xfer("t3");

    // zero length
    start_xfer(12'h055, 13'd0);
    run_wait(0, -1, 20, cyc, fv, b0);
    check("t4_done_cycle", 64'(cyc), 64'd0);
    check("t4_no_valid", 64'(fv), -64'sd1);
    check("t4_busy", 64'(b0), 64'd0);
    finish_xfer("t4");

    // start pulsed mid-transfer is ignored
    start_xfer(12'h040, 13'd8);
    run_wait(1, 3, 200, cyc, fv, b0);
    finish_xfer("t5");

    // random back-pressure
    start_xfer(12'h100, 13'd16);
    run_wait(2, -1, 400, cyc, fv, b0);
    finish_xfer("t6");

    // full address space, wraps through 0
    start_xfer(12'h800, 13'h1000);
    run_wait(0, -1, 5000, cyc, fv, b0);
    check("t7_done_cycle", 64'(cyc), 64'd4097);
    finish_xfer("t7");

    // reset after two words of a len=8 transfer
    start_xfer(12'h200, 13'd8);
    m_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("t8_popped_two", 64'(exp_q.size()), 64'd6);
    check("t8_busy", 64'(busy), 64'd0);
    check("t8_done", 64'(done), 64'd0);
    check("t8_addr", 64'(ram_addr), 64'd0);
    check("t8_valid", 64'(m_valid), 64'd0);
    check("t8_data", 64'(m_data), 64'd0);
    check("t8_last", 64'(m_last), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t8_no_done", 64'(done), 64'd0);
      check("t8_no_valid", 64'(m_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    start_xfer(12'h012, 13'd1);
    run_wait(0, -1, 50, cyc, fv, b0);
    check("t9_first_valid", 64'(fv), 64'd2);
    check("t9_done_cycle", 64'(cyc), 64'd2);
    finish_xfer("t9");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
